luma_frame_ctrl: RTL

LUMA_FRAME_CTRL -- requirements
Module: luma_frame_ctrl

---
 rtl/luma_frame_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/luma_frame_ctrl.sv
// Frame/line tracker for an RGB video stream feeding the luma pipeline.
// Gates data valid to whole frames and reports coordinates, framing pulses and length errors.
module luma_frame_ctrl #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          err_clr_i,
    input  logic [23:0]   rgb_i,
    input  logic          dv_i,
    input  logic          hs_i,
    input  logic          vs_i,
    output logic [23:0]   rgb_o,
    output logic          dv_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic          eof_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam logic [CW-1:0] HActiveC = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VActiveC = CW'(V_ACTIVE);
    localparam logic [CW-1:0] CntMax   = {CW{1'b1}};
    localparam logic [CW-1:0] CntOne   = CW'(1);

    typedef enum logic [1:0] {StIdle, StSync, StActive} state_e;

    state_e state_q, state_d;

    logic          vs_prev_q, dv_prev_q;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          armed_q, armed_d;
    logic          err_q, err_d;

    logic [23:0]   rgb_q;
    logic          dv_q, dv_d;
    logic          hs_q, vs_q;
    logic [CW-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic          sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic          busy_q;

    logic          vs_rise, line_end, is_active, frame_start;
    logic [CW-1:0] x_inc, y_inc;

    assign vs_rise     = vs_i & ~vs_prev_q;
    assign line_end    = dv_prev_q & ~dv_i;
    assign is_active   = (state_q == StActive);
    // A vs edge that leaves us in ACTIVE (entering or continuing) starts a fresh frame.
    assign frame_start = vs_rise & (state_d == StActive);
    assign x_inc       = (x_q == CntMax) ? x_q : x_q + CntOne;
    assign y_inc       = (y_q == CntMax) ? y_q : y_q + CntOne;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en_i) state_d = StSync;
            end
            StSync: begin
                if (vs_rise)    state_d = StActive;
                else if (!en_i) state_d = StIdle;
            end
            StActive: begin
                // en_i is only honoured at a frame boundary.
                if (vs_rise && !en_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        armed_d = armed_q;
        err_d   = err_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        dv_d    = dv_i & is_active;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        eof_d   = 1'b0;

        if (err_clr_i) err_d = 1'b0;

        if (is_active) begin
            if (dv_i) begin
                x_out_d = x_q;
                y_out_d = y_q;
                x_d     = x_inc;
                if (armed_q) begin
                    sof_d   = 1'b1;
                    armed_d = 1'b0;
                end
            end
            if (line_end) begin
                eol_d = 1'b1;
                eof_d = (y_inc == VActiveC);
                x_d   = '0;
                y_d   = y_inc;
                if (x_q != HActiveC) err_d = 1'b1;
            end
            if (vs_rise && (y_q != VActiveC)) err_d = 1'b1;
        end

        if (frame_start) begin
            x_d     = '0;
            y_d     = '0;
            armed_d = 1'b1;
        end else if (state_d != StActive) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            dv_prev_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            armed_q   <= 1'b0;
            err_q     <= 1'b0;
            rgb_q     <= '0;
            dv_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            x_out_q   <= '0;
            y_out_q   <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            vs_prev_q <= vs_i;
            dv_prev_q <= dv_i;
            x_q       <= x_d;
            y_q       <= y_d;
            armed_q   <= armed_d;
            err_q     <= err_d;
            rgb_q     <= rgb_i;
            dv_q      <= dv_d;
            hs_q      <= hs_i;
            vs_q      <= vs_i;
            x_out_q   <= x_out_d;
            y_out_q   <= y_out_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            eof_q     <= eof_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    assign rgb_o  = rgb_q;
    assign dv_o   = dv_q;
    assign hs_o   = hs_q;
    assign vs_o   = vs_q;
    assign x_o    = x_out_q;
    assign y_o    = y_out_q;
    assign sof_o  = sof_q;
    assign eol_o  = eol_q;
    assign eof_o  = eof_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule
